// File: rtl/snake_menu_cmdgen_if.sv
// Draw-command stream plus script ROM port for the snake menu command generator.
// The generator is the master: it drives cmd/cmd_vld and the ROM address.
interface snake_menu_cmdgen_if #(
  parameter int CMD_WIDTH = 32,
  parameter int SCRIPT_AW = 7
);
  logic [CMD_WIDTH-1:0] cmd;
  logic                 cmd_vld;
  logic                 cmd_rdy;
  logic [SCRIPT_AW-1:0] script_addr;
  logic [CMD_WIDTH-1:0] script_data;

  modport master (
    output cmd,
    output cmd_vld,
    input  cmd_rdy,
    output script_addr,
    input  script_data
  );

  modport slave (
    input  cmd,
    input  cmd_vld,
    output cmd_rdy,
    input  script_addr,
    output script_data
  );
endinterface

// File: rtl/snake_menu_cmdgen.sv
// Menu-screen command generator: replays a static draw script from a
// synchronous ROM, then draws one highlight bar pair per option and redraws
// the bars whenever navigation moves the selection.
module snake_menu_cmdgen #(
  parameter int         CMD_WIDTH    = 32,
  parameter int         NUM_OPTS     = 4,
  parameter int         OPT_ID_WIDTH = 3,
  parameter int         SCRIPT_LEN   = 78,
  parameter int         SCRIPT_AW    = 7,
  parameter logic [9:0] BAR_X0       = 10'd272,
  parameter logic [9:0] BAR_X1       = 10'd368,
  parameter logic [8:0] BAR_Y0       = 9'd362,
  parameter logic [8:0] BAR_DY       = 9'd25,
  parameter logic [7:0] HI_COLOR     = 8'h3c,
  parameter logic [7:0] LO_COLOR     = 8'hff
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enb,
  input  logic                    i_up,
  input  logic                    i_down,
  input  logic                    i_confirm,
  snake_menu_cmdgen_if.master     bus,
  output logic [OPT_ID_WIDTH-1:0] o_opt_id,
  output logic                    o_sel_vld,
  output logic [OPT_ID_WIDTH-1:0] o_sel_id,
  output logic                    o_busy
);

  // Bar counter spans 0..2*NUM_OPTS-1; one extra bit over the option index.
  localparam int KW = OPT_ID_WIDTH + 1;
  localparam logic [KW-1:0]           K_LAST    = KW'(2 * NUM_OPTS - 1);
  localparam logic [SCRIPT_AW-1:0]    ADDR_LAST = SCRIPT_AW'(SCRIPT_LEN - 1);
  localparam logic [OPT_ID_WIDTH-1:0] OPT_LAST  = OPT_ID_WIDTH'(NUM_OPTS - 1);
  localparam logic [OPT_ID_WIDTH-1:0] OPT_ZERO  = {OPT_ID_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_BARS  = 3'd4,
    ST_READY = 3'd5
  } state_t;

  state_t                  r_state,   w_state;
  logic [SCRIPT_AW-1:0]    r_addr,    w_addr;
  logic [CMD_WIDTH-1:0]    r_cmd,     w_cmd;
  logic                    r_cmd_vld, w_cmd_vld;
  logic [OPT_ID_WIDTH-1:0] r_opt,     w_opt;
  logic [OPT_ID_WIDTH-1:0] r_snap,    w_snap;
  logic [KW-1:0]           r_k,       w_k;
  logic                    r_sel_vld, w_sel_vld;
  logic [OPT_ID_WIDTH-1:0] r_sel_id,  w_sel_id;
  logic                    r_busy,    w_busy;

  logic                    w_xfer;
  logic                    w_nav_ok;
  logic [OPT_ID_WIDTH-1:0] w_opt_nav;

  // Bar word k of a pass: even k is the left end, odd k the right end of
  // option k>>1; the snapshot option gets the highlight colour.
  function automatic logic [CMD_WIDTH-1:0] bar_word(
    input logic [KW-1:0]           k,
    input logic [OPT_ID_WIDTH-1:0] snap
  );
    logic [OPT_ID_WIDTH-1:0] idx;
    logic [8:0]              y;
    logic [7:0]              c;
    logic [9:0]              x;
    logic [31:0]             w;
    idx = k[KW-1:1];
    y   = BAR_Y0 + (9'(idx) * BAR_DY);
    c   = (idx == snap) ? HI_COLOR : LO_COLOR;
    x   = k[0] ? BAR_X1 : BAR_X0;
    w   = {4'h9, x, y, c, k[0]};
    return CMD_WIDTH'(w);
  endfunction

  assign w_xfer   = r_cmd_vld & bus.cmd_rdy;
  assign w_nav_ok = ((r_state == ST_BARS) || (r_state == ST_READY)) &&
                    i_enb && (i_up ^ i_down);

  // Selection after this cycle's navigation (wraps at both ends).
  always_comb begin
    w_opt_nav = r_opt;
    if (w_nav_ok) begin
      if (i_up) begin
        w_opt_nav = (r_opt == OPT_ZERO) ? OPT_LAST : (r_opt - OPT_ID_WIDTH'(1));
      end else begin
        w_opt_nav = (r_opt == OPT_LAST) ? OPT_ZERO : (r_opt + OPT_ID_WIDTH'(1));
      end
    end else begin
      w_opt_nav = r_opt;
    end
  end

  // Next-state and next-output logic for the script/bars sequencer.
  always_comb begin
    w_state   = r_state;
    w_addr    = r_addr;
    w_cmd     = r_cmd;
    w_cmd_vld = r_cmd_vld;
    w_opt     = w_opt_nav;
    w_snap    = r_snap;
    w_k       = r_k;
    w_sel_vld = 1'b0;
    w_sel_id  = r_sel_id;
    w_busy    = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (i_enb) begin
          w_state = ST_FETCH;
          w_addr  = {SCRIPT_AW{1'b0}};
          w_busy  = 1'b1;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // ROM address settles here; data is valid in LOAD.
        if (i_enb) begin
          w_state = ST_LOAD;
        end else begin
          w_state = ST_FETCH;
        end
      end
      ST_LOAD: begin
        if (i_enb) begin
          w_cmd     = bus.script_data;
          w_cmd_vld = 1'b1;
          w_state   = ST_SEND;
        end else begin
          w_state = ST_LOAD;
        end
      end
      ST_SEND: begin
        // A pending word always completes, even with enb low.
        if (w_xfer) begin
          w_cmd_vld = 1'b0;
          if (r_addr == ADDR_LAST) begin
            w_state = ST_BARS;
            w_snap  = r_opt;
            w_k     = {KW{1'b0}};
          end else begin
            w_addr  = r_addr + SCRIPT_AW'(1);
            w_state = ST_FETCH;
          end
        end else begin
          w_state = ST_SEND;
        end
      end
      ST_BARS: begin
        if (r_cmd_vld) begin
          if (w_xfer) begin
            if (r_k == K_LAST) begin
              // End of pass: redraw once more if the selection moved meanwhile.
              w_cmd_vld = 1'b0;
              w_k       = {KW{1'b0}};
              if (w_opt_nav != r_snap) begin
                w_snap  = w_opt_nav;
                w_state = ST_BARS;
              end else begin
                w_state = ST_READY;
                w_busy  = 1'b0;
              end
            end else begin
              w_k = r_k + KW'(1);
              if (i_enb) begin
                w_cmd     = bar_word(r_k + KW'(1), r_snap);
                w_cmd_vld = 1'b1;
              end else begin
                w_cmd_vld = 1'b0;
              end
            end
          end else begin
            w_state = ST_BARS;
          end
        end else if (i_enb) begin
          w_cmd     = bar_word(r_k, r_snap);
          w_cmd_vld = 1'b1;
        end else begin
          w_state = ST_BARS;
        end
      end
      ST_READY: begin
        if (w_nav_ok) begin
          w_state = ST_BARS;
          w_snap  = w_opt_nav;
          w_k     = {KW{1'b0}};
          w_busy  = 1'b1;
        end else if (i_enb && i_confirm) begin
          w_sel_vld = 1'b1;
          w_sel_id  = r_opt;
        end else begin
          w_state = ST_READY;
        end
      end
      default: begin
        w_state   = ST_IDLE;
        w_cmd_vld = 1'b0;
        w_busy    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= {SCRIPT_AW{1'b0}};
      r_cmd     <= {CMD_WIDTH{1'b0}};
      r_cmd_vld <= 1'b0;
      r_opt     <= OPT_ZERO;
      r_snap    <= OPT_ZERO;
      r_k       <= {KW{1'b0}};
      r_sel_vld <= 1'b0;
      r_sel_id  <= OPT_ZERO;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_addr    <= w_addr;
      r_cmd     <= w_cmd;
      r_cmd_vld <= w_cmd_vld;
      r_opt     <= w_opt;
      r_snap    <= w_snap;
      r_k       <= w_k;
      r_sel_vld <= w_sel_vld;
      r_sel_id  <= w_sel_id;
      r_busy    <= w_busy;
    end
  end

  assign bus.script_addr = r_addr;
  assign bus.cmd         = r_cmd;
  assign bus.cmd_vld     = r_cmd_vld;
  assign o_opt_id        = r_opt;
  assign o_sel_vld       = r_sel_vld;
  assign o_sel_id        = r_sel_id;
  assign o_busy          = r_busy;

endmodule
